// File: rtl/npt_pkg.sv
// Shared definitions for the NPU convolution sequencer: FSM encoding and width helper.
package npt_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Address/counter width for a range of v values; a zero-width vector is never produced.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/npt_conv_seq_if.sv
// Control and buffer-address bundle between the convolution sequencer and its buffers/MAC.
interface npt_conv_seq_if
    import npt_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3
);
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int OUT_H  = IMG_H - K + 1;
    localparam int IN_AW  = clog2_min1(IMG_W * IMG_H);
    localparam int W_AW   = clog2_min1(K * K);
    localparam int OUT_AW = clog2_min1(OUT_W * OUT_H);

    logic              i_start;
    logic              o_busy;
    logic              o_rd_en;
    logic [IN_AW-1:0]  o_in_addr;
    logic [W_AW-1:0]   o_w_addr;
    logic              o_mac_en;
    logic              o_mac_clr;
    logic              o_out_we;
    logic [OUT_AW-1:0] o_out_addr;
    logic              o_done;

    modport master (
        input  i_start,
        output o_busy, o_rd_en, o_in_addr, o_w_addr, o_mac_en, o_mac_clr,
               o_out_we, o_out_addr, o_done
    );

    modport slave (
        output i_start,
        input  o_busy, o_rd_en, o_in_addr, o_w_addr, o_mac_en, o_mac_clr,
               o_out_we, o_out_addr, o_done
    );

endinterface

// File: rtl/npt_delay_line.sv
// Fixed-depth shift register that carries per-tap control alongside the buffer read latency.
module npt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_sr [DEPTH];

    // NOTE: every stage is cleared, not just the head, so no stale strobe can leak out after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/npt_conv_seq.sv
// Convolution sequencer: walks output pixels and kernel taps, issues buffer reads,
// and drives MAC clear/enable and output writes aligned to the buffer read latency.
module npt_conv_seq
    import npt_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int RD_LAT = 1
)(
    input  logic           i_clk,
    input  logic           i_rst,
    npt_conv_seq_if.master bus
);
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int OUT_H  = IMG_H - K + 1;
    localparam int IN_AW  = clog2_min1(IMG_W * IMG_H);
    localparam int W_AW   = clog2_min1(K * K);
    localparam int OUT_AW = clog2_min1(OUT_W * OUT_H);
    localparam int KW     = clog2_min1(K);
    localparam int XW     = clog2_min1(OUT_W);
    localparam int YW     = clog2_min1(OUT_H);

    logic [1:0]        r_state;
    logic [KW-1:0]     r_kx, r_ky;
    logic [XW-1:0]     r_ox;
    logic [YW-1:0]     r_oy;

    logic              w_run;
    logic              w_kx_last, w_ky_last, w_ox_last, w_oy_last, w_tap_last;
    logic [IN_AW-1:0]  w_in_addr;
    logic [W_AW-1:0]   w_w_addr;
    logic [OUT_AW-1:0] w_pix_addr;
    logic [OUT_AW+2:0] w_tap_d, w_tap_q;
    logic [OUT_AW:0]   w_wr_d, w_wr_q;
    logic              w_mac_en, w_mac_clr, w_pix_last_q;
    logic [OUT_AW-1:0] w_pix_addr_q;
    logic              w_out_we;
    logic [OUT_AW-1:0] w_out_addr;

    assign w_run      = (r_state == S_RUN);
    assign w_kx_last  = (r_kx == KW'(K - 1));
    assign w_ky_last  = (r_ky == KW'(K - 1));
    assign w_ox_last  = (r_ox == XW'(OUT_W - 1));
    assign w_oy_last  = (r_oy == YW'(OUT_H - 1));
    assign w_tap_last = w_kx_last & w_ky_last & w_ox_last & w_oy_last;

    // Counters wrap to zero after the final tap, so addresses read zero outside RUN.
    assign w_in_addr  = (IN_AW'(r_oy) + IN_AW'(r_ky)) * IN_AW'(IMG_W) + IN_AW'(r_ox) + IN_AW'(r_kx);
    assign w_w_addr   = W_AW'(r_ky) * W_AW'(K) + W_AW'(r_kx);
    assign w_pix_addr = w_run ? (OUT_AW'(r_oy) * OUT_AW'(OUT_W) + OUT_AW'(r_ox)) : '0;

    assign w_tap_d = {w_run,
                      w_run & (r_kx == '0) & (r_ky == '0),
                      w_run & w_kx_last & w_ky_last,
                      w_pix_addr};

    npt_delay_line #(.WIDTH(OUT_AW + 3), .DEPTH(RD_LAT)) u_rd_dly (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (w_tap_d),
        .o_q   (w_tap_q)
    );

    assign {w_mac_en, w_mac_clr, w_pix_last_q, w_pix_addr_q} = w_tap_q;
    assign w_wr_d = {w_pix_last_q, w_pix_addr_q};

    // One extra stage: the MAC result is valid the cycle after its last accumulate.
    npt_delay_line #(.WIDTH(OUT_AW + 1), .DEPTH(1)) u_wr_dly (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (w_wr_d),
        .o_q   (w_wr_q)
    );

    assign {w_out_we, w_out_addr} = w_wr_q;

    // NOTE: state and counters use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_kx    <= '0;
            r_ky    <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= S_RUN;
                        r_kx    <= '0;
                        r_ky    <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                    end
                end
                S_RUN: begin
                    r_kx <= w_kx_last ? '0 : r_kx + 1'b1;
                    if (w_kx_last)
                        r_ky <= w_ky_last ? '0 : r_ky + 1'b1;
                    if (w_kx_last && w_ky_last)
                        r_ox <= w_ox_last ? '0 : r_ox + 1'b1;
                    if (w_kx_last && w_ky_last && w_ox_last)
                        r_oy <= w_oy_last ? '0 : r_oy + 1'b1;
                    if (w_tap_last)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_out_we && (w_out_addr == OUT_AW'(OUT_W * OUT_H - 1)))
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy     = (r_state != S_IDLE);
    assign bus.o_rd_en    = w_run;
    assign bus.o_in_addr  = w_in_addr;
    assign bus.o_w_addr   = w_w_addr;
    assign bus.o_mac_en   = w_mac_en;
    assign bus.o_mac_clr  = w_mac_clr;
    assign bus.o_out_we   = w_out_we;
    assign bus.o_out_addr = w_out_addr;
    assign bus.o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_npt_conv_seq.sv
// Self-checking bench: four sequencer configurations against a direct convolution model.
module tb_npt_conv_seq;

    localparam int NC = 4;

    // Configurations: {IMG_W, IMG_H, K, RD_LAT}
    function automatic int cfg(input int i, input int f);
        int w, h, k, l;
        case (i)
            0:       begin w = 8; h = 8; k = 3; l = 1; end
            1:       begin w = 8; h = 8; k = 3; l = 3; end
            2:       begin w = 4; h = 4; k = 1; l = 1; end
            default: begin w = 3; h = 3; k = 3; l = 2; end
        endcase
        case (f)
            0:       return w;
            1:       return h;
            2:       return k;
            default: return l;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic start_v [NC];
    logic rst_v   [NC];
    logic clr_req [NC];

    logic mon_busy [NC], mon_rd [NC], mon_mac [NC], mon_clr [NC], mon_we [NC], mon_done [NC];
    int   mon_in [NC], mon_w [NC], mon_out [NC];

    for (genvar gi = 0; gi < NC; gi++) begin : g
        localparam int GW = cfg(gi, 0);
        localparam int GH = cfg(gi, 1);
        localparam int GK = cfg(gi, 2);
        localparam int GL = cfg(gi, 3);

        npt_conv_seq_if #(.IMG_W(GW), .IMG_H(GH), .K(GK)) bus ();

        assign bus.i_start = start_v[gi];

        npt_conv_seq #(.IMG_W(GW), .IMG_H(GH), .K(GK), .RD_LAT(GL)) dut (
            .i_clk (clk),
            .i_rst (rst_v[gi]),
            .bus   (bus)
        );

        assign mon_busy[gi] = bus.o_busy;
        assign mon_rd[gi]   = bus.o_rd_en;
        assign mon_mac[gi]  = bus.o_mac_en;
        assign mon_clr[gi]  = bus.o_mac_clr;
        assign mon_we[gi]   = bus.o_out_we;
        assign mon_done[gi] = bus.o_done;
        assign mon_in[gi]   = int'(bus.o_in_addr);
        assign mon_w[gi]    = int'(bus.o_w_addr);
        assign mon_out[gi]  = int'(bus.o_out_addr);
    end

    // Buffer contents seen by the reference MAC.
    int fm [64];
    int wt [9];

    // Captured activity, written only by the monitor below.
    int n_rd [NC], n_we [NC], n_clr [NC], n_done [NC];
    int first_rd [NC], done_at [NC], idle_err [NC], mac_err [NC], acc [NC];
    int rd_in [NC][$], rd_w [NC][$], wr_addr [NC][$], wr_val [NC][$], clr_seq [NC][$];
    int pend_p [NC][$], pend_c [NC][$];

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor + behavioural MAC: data returns RD_LAT cycles after the read, results latch on write.
    always @(negedge clk) begin
        int p, c;
        for (int i = 0; i < NC; i++) begin
            if (clr_req[i]) begin
                n_rd[i] = 0; n_we[i] = 0; n_clr[i] = 0; n_done[i] = 0;
                first_rd[i] = -1; done_at[i] = -1; idle_err[i] = 0; mac_err[i] = 0; acc[i] = 0;
                rd_in[i].delete(); rd_w[i].delete(); wr_addr[i].delete(); wr_val[i].delete();
                clr_seq[i].delete(); pend_p[i].delete(); pend_c[i].delete();
            end else begin
                if (!mon_busy[i] && (mon_rd[i] || mon_mac[i] || mon_clr[i] || mon_we[i] || mon_done[i]
                                     || mon_in[i] != 0 || mon_w[i] != 0 || mon_out[i] != 0))
                    idle_err[i]++;
                if (mon_we[i]) begin
                    wr_addr[i].push_back(mon_out[i]);
                    wr_val[i].push_back(acc[i]);
                    n_we[i]++;
                end
                if (mon_mac[i]) begin
                    if (pend_p[i].size() == 0) begin
                        mac_err[i]++;
                    end else begin
                        p = pend_p[i].pop_front();
                        c = pend_c[i].pop_front();
                        if (cyc - c != cfg(i, 3)) mac_err[i]++;
                        acc[i] = mon_clr[i] ? p : acc[i] + p;
                    end
                    clr_seq[i].push_back(int'(mon_clr[i]));
                    if (mon_clr[i]) n_clr[i]++;
                end else if (mon_clr[i]) begin
                    mac_err[i]++;
                end
                if (mon_rd[i]) begin
                    if (n_rd[i] == 0) first_rd[i] = cyc;
                    n_rd[i]++;
                    rd_in[i].push_back(mon_in[i]);
                    rd_w[i].push_back(mon_w[i]);
                    pend_p[i].push_back(fm[mon_in[i] % 64] * wt[mon_w[i] % 9]);
                    pend_c[i].push_back(cyc);
                end
                if (mon_done[i]) begin
                    n_done[i]++;
                    done_at[i] = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int pat);
        for (int a = 0; a < 64; a++) fm[a] = (pat == 0) ? a : int'($urandom_range(0, 255));
        for (int a = 0; a < 9; a++)  wt[a] = (pat == 0) ? 1 : int'($urandom_range(0, 15));
    endtask

    task automatic clear_mon(input int idx);
        clr_req[idx] = 1'b1;
        tick();
        clr_req[idx] = 1'b0;
    endtask

    task automatic run_cfg(input int idx, input int pat, input int mid_start);
        int w, h, k, l, ow, oh, npix, n, t0, b, err;
        int exp_in [$], exp_w [$], exp_out [$];
        w = cfg(idx, 0); h = cfg(idx, 1); k = cfg(idx, 2); l = cfg(idx, 3);
        ow = w - k + 1; oh = h - k + 1; npix = ow * oh; n = npix * k * k;

        fill(pat);
        clear_mon(idx);
        start_v[idx] = 1'b1;
        t0 = cyc;
        tick();
        start_v[idx] = 1'b0;
        if (mid_start != 0) begin
            repeat (50) tick();
            start_v[idx] = 1'b1;
            tick();
            start_v[idx] = 1'b0;
        end
        b = 0;
        while (n_done[idx] == 0 && b < 3000) begin
            tick();
            b++;
        end
        repeat (10) tick();

        // Reference: direct valid convolution in loop order oy, ox, ky, kx.
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++) begin
                int s = 0;
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        exp_in.push_back((oy + ky) * w + ox + kx);
                        exp_w.push_back(ky * k + kx);
                        s += fm[(oy + ky) * w + ox + kx] * wt[ky * k + kx];
                    end
                exp_out.push_back(s);
            end

        check($sformatf("c%0d start_to_rd", idx), first_rd[idx] - t0, 1);
        check($sformatf("c%0d n_rd", idx), n_rd[idx], n);
        check($sformatf("c%0d n_we", idx), n_we[idx], npix);
        check($sformatf("c%0d n_clr", idx), n_clr[idx], npix);
        check($sformatf("c%0d n_done", idx), n_done[idx], 1);
        check($sformatf("c%0d done_lat", idx), done_at[idx] - first_rd[idx], n + l + 1);
        check($sformatf("c%0d mac_align", idx), mac_err[idx], 0);
        check($sformatf("c%0d idle_outs", idx), idle_err[idx], 0);

        err = 0;
        for (int j = 0; j < n; j++)
            if (j >= rd_in[idx].size() || rd_in[idx][j] != exp_in[j] || rd_w[idx][j] != exp_w[j]) err++;
        check($sformatf("c%0d rd_addr_seq", idx), err, 0);

        err = 0;
        for (int j = 0; j < n; j++)
            if (j >= clr_seq[idx].size() || clr_seq[idx][j] != ((j % (k * k) == 0) ? 1 : 0)) err++;
        check($sformatf("c%0d clr_pattern", idx), err, 0);

        err = 0;
        for (int p = 0; p < npix; p++)
            if (p >= wr_addr[idx].size() || wr_addr[idx][p] != p || wr_val[idx][p] != exp_out[p]) err++;
        check($sformatf("c%0d wr_seq", idx), err, 0);

        if (pat == 0 && k == 3 && w == 8 && h == 8) begin
            check($sformatf("c%0d out0", idx), (wr_val[idx].size() > 0) ? wr_val[idx][0] : -1, 81);
            check($sformatf("c%0d out35", idx), (wr_val[idx].size() > 35) ? wr_val[idx][35] : -1, 486);
            check($sformatf("c%0d last_px_in0", idx), (rd_in[idx].size() == n) ? rd_in[idx][n - 9] : -1, 45);
            check($sformatf("c%0d last_px_in8", idx), (rd_in[idx].size() == n) ? rd_in[idx][n - 1] : -1, 63);
        end
    endtask

    task automatic reset_mid_run();
        int b, we_snap;
        fill(1);
        clear_mon(0);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        b = 0;
        while (n_rd[0] < 100 && b < 1000) begin
            tick();
            b++;
        end
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        we_snap = n_we[0];
        @(negedge clk);
        check("rst busy", int'(mon_busy[0]), 0);
        check("rst rd_en", int'(mon_rd[0]), 0);
        repeat (400) tick();
        check("rst no_write", n_we[0], we_snap);
        check("rst no_done", n_done[0], 0);
        check("rst idle_outs", idle_err[0], 0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            start_v[i] = 1'b0;
            rst_v[i]   = 1'b1;
            clr_req[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < NC; i++) rst_v[i] = 1'b0;
        for (int i = 0; i < NC; i++) clear_mon(i);

        repeat (20) tick();
        for (int i = 0; i < NC; i++) begin
            check($sformatf("c%0d reset_idle_outs", i), idle_err[i], 0);
            check($sformatf("c%0d reset_busy", i), int'(mon_busy[i]), 0);
            check($sformatf("c%0d reset_no_rd", i), n_rd[i], 0);
        end

        run_cfg(0, 0, 0);
        run_cfg(1, 0, 0);
        run_cfg(1, 1, 1);
        run_cfg(0, 1, 1);
        run_cfg(2, 1, 0);
        run_cfg(3, 1, 0);
        reset_mid_run();
        run_cfg(0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
